// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: groups an untagged beat stream into pkt_len-beat packets with tlast.
// Define AXIS_PACKETIZER_STATS_EN to add the pkt_count completed-packet counter output.
module axis_packetizer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  flush,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  busy
`ifdef AXIS_PACKETIZER_STATS_EN
    ,
    output logic [31:0]           pkt_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH:0] ONE      = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH:0] FULL_LEN = {1'b1, {LEN_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [LEN_WIDTH:0]      len_q, len_d;
    logic [LEN_WIDTH:0]      cnt_q, cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    busy_q, busy_d;

    logic                    accept;
    logic                    flush_eff;
    logic                    last_beat;
    logic [LEN_WIDTH:0]      start_len;
    logic [LEN_WIDTH:0]      cnt_inc;

    assign s_axis_tready = !rst && (!m_valid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign flush_eff     = flush || flush_pend_q;
    // A zero length field encodes the largest packet, 2^LEN_WIDTH beats.
    assign start_len     = (pkt_len == '0) ? FULL_LEN : {1'b0, pkt_len};
    assign cnt_inc       = cnt_q + ONE;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        last_beat    = 1'b0;

        if (accept) begin
            flush_pend_d = 1'b0;
            if (state_q == IDLE) begin
                len_d     = start_len;
                cnt_d     = ONE;
                last_beat = (start_len == ONE) || flush_eff;
            end else begin
                cnt_d     = cnt_inc;
                last_beat = (cnt_inc == len_q) || flush_eff;
            end
            state_d   = last_beat ? IDLE : BODY;
            m_valid_d = 1'b1;
            m_data_d  = s_axis_tdata;
            m_last_d  = last_beat;
        end else begin
            if (flush) begin
                flush_pend_d = 1'b1;
            end
            if (m_axis_tready) begin
                m_valid_d = 1'b0;
            end
        end

        busy_d = (state_d == BODY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign busy          = busy_q;

`ifdef AXIS_PACKETIZER_STATS_EN
    logic [31:0] pkt_count_q;

    // A packet completes when its tlast beat leaves the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (m_valid_q && m_axis_tready && m_last_q) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule
